// File: rtl/sram22_mbist_pkg.sv
// Shared types and the March C- element table for the SRAM22 built-in self-test.
package sram22_mbist_pkg;

   localparam int NUM_ELEMS = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef logic [2:0] elem_t;

   typedef struct packed {
      logic down;     // 1 = address N-1 down to 0
      logic has_rd;
      logic rd_val;   // expected background for the read
      logic has_wr;
      logic wr_val;   // background written
   } march_t;

   localparam march_t MARCH_E0 = '{down: 1'b0, has_rd: 1'b0, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b0};
   localparam march_t MARCH_E1 = '{down: 1'b0, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1};
   localparam march_t MARCH_E2 = '{down: 1'b0, has_rd: 1'b1, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0};
   localparam march_t MARCH_E3 = '{down: 1'b1, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1};
   localparam march_t MARCH_E4 = '{down: 1'b1, has_rd: 1'b1, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0};
   localparam march_t MARCH_E5 = '{down: 1'b0, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b0, wr_val: 1'b0};

   function automatic march_t march_entry(elem_t e);
      case (e)
         3'd0:    return MARCH_E0;
         3'd1:    return MARCH_E1;
         3'd2:    return MARCH_E2;
         3'd3:    return MARCH_E3;
         3'd4:    return MARCH_E4;
         default: return MARCH_E5;
      endcase
   endfunction

endpackage

// File: rtl/sram22_mbist_if.sv
// Single-port SRAM22 macro port: the self-test drives it as master, the macro is the slave.
interface sram22_mbist_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 11,
   parameter int WMASK_WIDTH = 4
);
   logic                   we;
   logic [WMASK_WIDTH-1:0] wmask;
   logic [ADDR_WIDTH-1:0]  addr;
   logic [DATA_WIDTH-1:0]  din;
   logic [DATA_WIDTH-1:0]  dout;

   modport master (output we, wmask, addr, din, input dout);
   modport slave  (input we, wmask, addr, din, output dout);
endinterface

// File: rtl/sram22_mbist_addr_gen.sv
// Loadable up/down address counter; first/last flags are relative to the current direction.
module sram22_mbist_addr_gen #(
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  load_down,
   input  logic                  step,
   input  logic                  down,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  first,
   output logic                  last
);
   localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_down ? ADDR_TOP : '0;
      end else if (step) begin
         addr <= down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
      end
   end

   assign first = (addr == (down ? ADDR_TOP : '0));
   assign last  = (addr == (down ? '0 : ADDR_TOP));

endmodule

// File: rtl/sram22_mbist.sv
// March C- self-test initiator for SRAM22: issues one op per cycle and checks every read.
module sram22_mbist
   import sram22_mbist_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 11,
   parameter int WMASK_WIDTH = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output elem_t                 fail_elem,
   output logic [CNT_WIDTH-1:0]  fail_count,
   sram22_mbist_if.master        sram
);
   state_t                state, state_nxt;
   logic                  issue;
   elem_t                 elem, elem_nxt;
   logic                  phase;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  addr_first, addr_last;
   march_t                cur, nxt;
   logic                  cur_rd, cur_wr, addr_done, elem_done, cur_last;
   logic                  port_rd, port_exp, port_last;
   elem_t                 port_elem;
   logic                  pend, pend_val;
   logic [ADDR_WIDTH-1:0] pend_addr;
   elem_t                 pend_elem;
   logic                  miscompare;

   // Decode of the next op to issue; the position wraps to op 0 after the final E5 read.
   assign cur       = march_entry(elem);
   assign cur_rd    = cur.has_rd & ~phase;
   assign cur_wr    = cur.has_wr & (~cur.has_rd | phase);
   assign addr_done = ~(cur.has_rd & cur.has_wr) | phase;
   assign elem_done = addr_done & addr_last;
   assign cur_last  = elem_done & (elem == elem_t'(NUM_ELEMS - 1));
   assign elem_nxt  = cur_last ? elem_t'(0) : elem + 3'd1;
   assign nxt       = march_entry(elem_nxt);

   sram22_mbist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (issue & elem_done),
      .load_down (nxt.down),
      .step      (issue & addr_done & ~addr_last),
      .down      (cur.down),
      .addr      (addr),
      .first     (addr_first),
      .last      (addr_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt = ST_RUN;
               issue     = 1'b1;
            end
         end
         ST_RUN: begin
            if (port_last) state_nxt = ST_DRAIN;
            else           issue     = 1'b1;
         end
         ST_DRAIN: state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign miscompare = (sram.dout !== {DATA_WIDTH{pend_val}});

   // NOTE: only control and status flops are reset; the macro array itself is never cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram.we    <= 1'b0;
         sram.wmask <= '0;
         sram.addr  <= '0;
         sram.din   <= '0;
         phase      <= 1'b0;
         elem       <= '0;
         port_rd    <= 1'b0;
         port_exp   <= 1'b0;
         port_elem  <= '0;
         port_last  <= 1'b0;
         pend       <= 1'b0;
         pend_val   <= 1'b0;
         pend_addr  <= '0;
         pend_elem  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         fail_addr  <= '0;
         fail_elem  <= '0;
         fail_count <= '0;
      end else begin
         sram.we    <= issue & cur_wr;
         sram.wmask <= (issue & cur_wr) ? '1 : '0;
         sram.addr  <= issue ? addr : '0;
         sram.din   <= (issue & cur_wr) ? {DATA_WIDTH{cur.wr_val}} : '0;
         port_rd    <= issue & cur_rd;
         port_exp   <= cur.rd_val;
         port_elem  <= elem;
         port_last  <= issue & cur_last;
         if (issue) begin
            phase <= ~addr_done;
            if (elem_done) elem <= elem_nxt;
         end

         // Read data arrives one cycle after the read edge, so the expectation rides one stage behind.
         pend      <= port_rd;
         pend_val  <= port_exp;
         pend_addr <= sram.addr;
         pend_elem <= port_elem;

         busy <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
         done <= (state_nxt == ST_DONE);

         if (issue && state != ST_RUN) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_count <= '0;
         end else if (pend && miscompare) begin
            if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
            if (!fail) begin
               fail      <= 1'b1;
               fail_addr <= pend_addr;
               fail_elem <= pend_elem;
            end
         end
      end
   end

   // While parked the position must sit on op 0, the first address of an ascending element.
   assert property (@(posedge clk) disable iff (!rst_n)
      (state == ST_IDLE || state == ST_DONE) |-> (addr_first && elem == elem_t'(0)));

endmodule

// File: tb/tb_sram22_mbist.sv
// Bench for sram22_mbist on a 16-word behavioural macro with injectable read faults.
module tb_sram22_mbist;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int MW = 4;
   localparam int CW = 16;
   localparam int N  = 1 << AW;
   localparam int NUM_OPS = 10 * N;

   typedef enum int {FM_NONE, FM_SA0, FM_SA1, FM_GARBAGE} fault_e;
   typedef logic [1+MW+AW+DW-1:0] op_t;

   // Independent March C- description: -1 means the element has no such op.
   localparam int RD_V [6] = '{-1, 0, 1, 0, 1,  0};
   localparam int WR_V [6] = '{ 0, 1, 0, 1, 0, -1};
   localparam bit DN_V [6] = '{ 0, 0, 0, 1, 1,  0};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          busy, done, fail;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_elem;
   logic [CW-1:0] fail_count;

   sram22_mbist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) sram_bus ();

   sram22_mbist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .fail_addr  (fail_addr),
      .fail_elem  (fail_elem),
      .fail_count (fail_count),
      .sram       (sram_bus)
   );

   always #5 clk = ~clk;

   fault_e          mode = FM_NONE;
   logic [DW-1:0]   mem [N];
   op_t             exp_q [$];
   int              n_checks = 0;
   int              n_fail = 0;
   int              m_cnt;
   logic [AW-1:0]   m_addr;
   logic [2:0]      m_elem;

   // Garbage stands in for an all-X macro: it mismatches both backgrounds on every read.
   function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] w, input logic [AW-1:0] a);
      logic [DW-1:0] r = w;
      case (mode)
         FM_SA0:     if (a == 4'd9) r[5] = 1'b0;
         FM_SA1:     if (a == 4'd3) r[0] = 1'b1;
         FM_GARBAGE: r = 32'hA5A5_5A5A;
         default:    r = w;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (sram_bus.we) begin
         for (int i = 0; i < MW; i++)
            if (sram_bus.wmask[i]) mem[sram_bus.addr][i*8 +: 8] <= sram_bus.din[i*8 +: 8];
      end else begin
         sram_bus.dout <= apply_fault(mem[sram_bus.addr], sram_bus.addr);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] port_now();
      return 64'({sram_bus.we, sram_bus.wmask, sram_bus.addr, sram_bus.din});
   endfunction

   function automatic logic [63:0] status_now();
      return 64'({busy, done, fail, fail_addr, fail_elem, fail_count});
   endfunction

   task automatic build_expected();
      logic [DW-1:0] bg;
      logic [AW-1:0] a;
      m_cnt  = 0;
      m_addr = '0;
      m_elem = '0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            a = AW'(DN_V[e] ? (N - 1 - i) : i);
            if (RD_V[e] >= 0) begin
               bg = (RD_V[e] == 1) ? '1 : '0;
               exp_q.push_back({1'b0, 4'h0, a, 32'h0});
               if (apply_fault(bg, a) !== bg) begin
                  if (m_cnt == 0) begin
                     m_addr = a;
                     m_elem = 3'(e);
                  end
                  m_cnt++;
               end
            end
            if (WR_V[e] >= 0)
               exp_q.push_back({1'b1, 4'hF, a, (WR_V[e] == 1) ? 32'hFFFF_FFFF : 32'h0});
         end
      end
   endtask

   task automatic run_march(input fault_e m, input int restart_at, input int abort_at);
      op_t exp_op;
      mode = m;
      build_expected();
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < NUM_OPS; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0;
            check("start_status", status_now(), 64'({1'b1, 1'b0, 1'b0, 4'h0, 3'h0, 16'h0}));
         end
         if (k == restart_at)     start = 1'b1;
         if (k == restart_at + 1) start = 1'b0;
         if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort_status", status_now(), 64'h0);
            check("abort_port", port_now(), 64'h0);
            exp_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (exp_q.size() == 0) begin
            check($sformatf("op%0d_underflow", k), 64'(exp_q.size()), 64'd1);
         end else begin
            exp_op = exp_q.pop_front();
            check($sformatf("op%0d", k), port_now(), 64'(exp_op));
         end
      end
      @(negedge clk);
      check("drain_busy_done", 64'({busy, done}), 64'({1'b1, 1'b0}));
      check("drain_port", port_now(), 64'h0);
      @(negedge clk);
      check("end_busy_done", 64'({busy, done}), 64'({1'b0, 1'b1}));
      check("end_fail", 64'(fail), 64'(m_cnt != 0));
      check("end_fail_count", 64'(fail_count), 64'(m_cnt));
      check("end_fail_addr", 64'(fail_addr), 64'(m_addr));
      check("end_fail_elem", 64'(fail_elem), 64'(m_elem));
      check("end_port", port_now(), 64'h0);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check("reset_status", status_now(), 64'h0);
      check("reset_port", port_now(), 64'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_status", status_now(), 64'h0);
      check("idle_port", port_now(), 64'h0);

      run_march(FM_SA0, -10, -10);
      run_march(FM_NONE, -10, -10);
      run_march(FM_SA1, -10, -10);
      run_march(FM_GARBAGE, -10, -10);
      run_march(FM_NONE, 49, -10);
      run_march(FM_SA1, -10, 69);
      check("post_abort_idle", status_now(), 64'h0);
      run_march(FM_NONE, -10, -10);

      repeat (4) @(negedge clk);
      check("done_hold", 64'({busy, done, fail}), 64'({1'b0, 1'b1, 1'b0}));
      check("done_port", port_now(), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
